frame_scheduler: RTL and testbench
==================================

# frame_scheduler

Sequences one display refresh from request to latch. On an `update_frame` pulse it walks `current_led` from 0 to MAX_POS-1, offering each index to the LED serializer through a valid/ready handshake. After the last pixel it holds the strip-latch (reset) period, then signals frame completion. It sits between `display_unit` (index consumer, `update_frame` producer) and the LED serializer.

## Interface
- MAX_POS, 16, number of LEDs per frame; ≥2
- LATCH_CYCLES, 2500, clk cycles of line-low latch time after the last pixel; ≥1
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- update_frame  in  1  frame request; level sampled each cycle, one-cycle pulse expected
- pixel_ready  in  1  serializer can accept the offered pixel
- current_led  out  $clog2(MAX_POS)  LED index being offered; drives `display_unit.current_led`
- pixel_valid  out  1  `current_led` is valid for transfer
- latch_active  out  1  high during the latch period
- frame_busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse at end of latch

## Operation
- States: IDLE, SEND, LATCH.
- IDLE: outputs idle. `update_frame`=1 moves to SEND, with current_led=0 and pixel_valid=1 on the next cycle.
- SEND: pixel_valid=1. A transfer occurs on a cycle with pixel_valid&pixel_ready.
  - Transfer with current_led<MAX_POS-1: increment current_led next cycle.
  - Transfer with current_led==MAX_POS-1: go to LATCH. current_led returns to 0 and pixel_valid drops next cycle.
  - Without pixel_ready, current_led and pixel_valid hold unchanged. No timeout.
- LATCH: latch_active=1 for exactly LATCH_CYCLES cycles, timed by a down-counter loaded with LATCH_CYCLES-1 on entry. When the counter reaches 0:
  - frame_done pulses on the following cycle.
  - The state goes to IDLE, or to SEND when a request is pending (see Configuration).
- `update_frame` during SEND/LATCH never restarts or alters the current frame.
- Arithmetic:
  - Index width is $clog2(MAX_POS); the index never exceeds MAX_POS-1.
  - Latch counter width is $clog2(LATCH_CYCLES+1); no wrap.
- Reset mid-frame returns to IDLE on the next edge and clears pending. The serializer sees pixel_valid fall without a transfer; this is legal.

## Timing
- Reset values: current_led=0, pixel_valid=0, latch_active=0, frame_busy=0, frame_done=0, state IDLE, pending=0.
- Request-to-first-valid latency: 1 cycle.
- With pixel_ready tied high: one pixel per cycle, and frame_done is asserted MAX_POS+LATCH_CYCLES+1 cycles after the update_frame cycle.
- frame_done coincides with the first IDLE cycle, or with the first SEND cycle of a pending frame.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- FRAME_SCHEDULER_PENDING_EN defined:
  - A one-bit pending flag is set by `update_frame` while frame_busy=1; multiple requests collapse to one.
  - At end of LATCH with pending=1, the scheduler enters SEND directly and clears pending.
  - `update_frame` on the final LATCH cycle also counts as pending.
- Undefined: requests while frame_busy=1 are dropped; the scheduler always returns to IDLE after LATCH.

## Structure
- Shared package `display_pkg` holds:
  - state encoding constants (IDLE=2'd0, SEND=2'd1, LATCH=2'd2)
  - the default LATCH_CYCLES value
- One sub-module, `latch_timer`:
  - load/count-down with a terminal-count pulse
  - parameterised by cycle count
  - instantiated in LATCH.

## Test plan
- MAX_POS=4, LATCH_CYCLES=3, pixel_ready=1, pulse update_frame at cycle 0 → indices 0,1,2,3 offered at cycles 1–4; latch_active cycles 5–7; frame_done at cycle 8; frame_busy low from cycle 8.
- Same config, pixel_ready low for 2 cycles while index 2 is offered → index 2 held for 3 cycles; frame_done at cycle 10.
- update_frame pulsed at cycle 3 (mid-SEND):
  - With FRAME_SCHEDULER_PENDING_EN: second frame starts at cycle 8, with current_led=0 and pixel_valid=1 in the same cycle as frame_done.
  - Without the macro: IDLE at cycle 8, no second frame.
- reset asserted at cycle 2 of SEND → next cycle all outputs at reset values; a later update_frame starts a clean frame from index 0.
- Continuous update_frame held high for 20 cycles with the macro defined → back-to-back frames, each offering all 4 indices; no frame started mid-frame.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the display refresh path: scheduler state encoding
// and the default strip-latch duration.
package display_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      LATCH = 2'd2
   } sched_state_e;

   localparam int unsigned LATCH_CYCLES_DEFAULT = 32'd2500;

endpackage

// File: rtl/latch_timer.sv
// Loadable down-counter that times the strip-latch period; o_tc is a registered
// flag that is high on the last enabled cycle of the period.
module latch_timer #(
   parameter  int unsigned CYCLES = 32'd2500,
   localparam int unsigned CW     = $clog2(CYCLES + 32'd1)
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_load,
   input  logic i_en,
   output logic o_tc
);

   logic [CW-1:0] r_count;
   logic          r_tc;

   // Count down from CYCLES-1; tc is raised one cycle early so it lands on count 0
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count <= '0;
         r_tc    <= 1'b0;
      end else if (i_load) begin
         r_count <= CW'(CYCLES - 32'd1);
         r_tc    <= (CYCLES == 32'd1);
      end else if (i_en && (r_count != '0)) begin
         r_count <= r_count - CW'(1);
         r_tc    <= (r_count == CW'(1));
      end else begin
         r_count <= r_count;
         r_tc    <= 1'b0;
      end
   end

   assign o_tc = r_tc;

endmodule

// File: rtl/frame_scheduler.sv
// Walks LED indices 0..MAX_POS-1 to the serializer, then holds the latch period.
// Define FRAME_SCHEDULER_PENDING_EN to queue one request arriving while busy.
module frame_scheduler
   import display_pkg::*;
#(
   parameter  int unsigned MAX_POS      = 32'd16,
   parameter  int unsigned LATCH_CYCLES = LATCH_CYCLES_DEFAULT,
   localparam int unsigned IW           = $clog2(MAX_POS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          update_frame,
   input  logic          pixel_ready,
   output logic [IW-1:0] current_led,
   output logic          pixel_valid,
   output logic          latch_active,
   output logic          frame_busy,
   output logic          frame_done
);

   sched_state_e  r_state;
   sched_state_e  w_state_next;
   logic [IW-1:0] r_led;
   logic [IW-1:0] w_led_next;
   logic          r_pixel_valid;
   logic          r_latch_active;
   logic          r_frame_busy;
   logic          r_frame_done;
   logic          w_done_next;
   logic          w_transfer;
   logic          w_last;
   logic          w_tc;
   logic          w_restart;

   assign w_transfer = (r_state == SEND) && pixel_ready;
   assign w_last     = (r_led == IW'(MAX_POS - 32'd1));

   latch_timer #(
      .CYCLES (LATCH_CYCLES)
   ) u_latch_timer (
      .i_clk   (clk),
      .i_reset (reset),
      .i_load  (w_transfer && w_last),
      .i_en    (r_state == LATCH),
      .o_tc    (w_tc)
   );

`ifdef FRAME_SCHEDULER_PENDING_EN
   logic r_pending;

   // A request seen while busy (including the final latch cycle) queues one frame
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pending <= 1'b0;
      end else if ((r_state == LATCH) && w_tc) begin
         r_pending <= 1'b0;
      end else if (update_frame && (r_state != IDLE)) begin
         r_pending <= 1'b1;
      end else begin
         r_pending <= r_pending;
      end
   end

   assign w_restart = r_pending | update_frame;
`else
   assign w_restart = 1'b0;
`endif

   // Next-state and next-output decode
   always_comb begin
      w_state_next = r_state;
      w_led_next   = r_led;
      w_done_next  = 1'b0;
      case (r_state)
         IDLE: begin
            w_led_next = '0;
            if (update_frame) begin
               w_state_next = SEND;
            end else begin
               w_state_next = IDLE;
            end
         end
         SEND: begin
            if (w_transfer && w_last) begin
               w_state_next = LATCH;
               w_led_next   = '0;
            end else if (w_transfer) begin
               w_led_next = r_led + IW'(1);
            end else begin
               w_led_next = r_led;
            end
         end
         LATCH: begin
            if (w_tc) begin
               w_done_next = 1'b1;
               if (w_restart) begin
                  w_state_next = SEND;
               end else begin
                  w_state_next = IDLE;
               end
            end else begin
               w_state_next = LATCH;
            end
         end
         default: begin
            w_state_next = IDLE;
            w_led_next   = '0;
         end
      endcase
   end

   // State register; outputs are registered from the next state
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= IDLE;
         r_led          <= '0;
         r_pixel_valid  <= 1'b0;
         r_latch_active <= 1'b0;
         r_frame_busy   <= 1'b0;
         r_frame_done   <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_led          <= w_led_next;
         r_pixel_valid  <= (w_state_next == SEND);
         r_latch_active <= (w_state_next == LATCH);
         r_frame_busy   <= (w_state_next != IDLE);
         r_frame_done   <= w_done_next;
      end
   end

   assign current_led  = r_led;
   assign pixel_valid  = r_pixel_valid;
   assign latch_active = r_latch_active;
   assign frame_busy   = r_frame_busy;
   assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler (MAX_POS=4, LATCH_CYCLES=3); expectations
// follow FRAME_SCHEDULER_PENDING_EN when the bench is built with it.
module tb_frame_scheduler;

   logic       clk;
   logic       reset;
   logic       update_frame;
   logic       pixel_ready;
   logic [1:0] current_led;
   logic       pixel_valid;
   logic       latch_active;
   logic       frame_busy;
   logic       frame_done;
   logic [5:0] w_obs;

   int         checks;
   int         failures;

   logic [5:0] exp_tbl [0:31];
   logic [31:0] upd_m;
   logic [31:0] rdy_lo_m;
   logic [31:0] rst_m;

   frame_scheduler #(
      .MAX_POS      (32'd4),
      .LATCH_CYCLES (32'd3)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .update_frame (update_frame),
      .pixel_ready  (pixel_ready),
      .current_led  (current_led),
      .pixel_valid  (pixel_valid),
      .latch_active (latch_active),
      .frame_busy   (frame_busy),
      .frame_done   (frame_done)
   );

   // {busy, done, latch, valid, led[1:0]}
   assign w_obs = {frame_busy, frame_done, latch_active, pixel_valid, current_led};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      upd_m    = 32'd0;
      rdy_lo_m = 32'd0;
      rst_m    = 32'd0;
      for (int i = 0; i < 32; i++) exp_tbl[i] = 6'h00;
   endtask

   // One full-speed frame starting at cycle s: 4 indices, 3 latch cycles, done+idle
   task automatic frame_exp(input int s);
      for (int k = 0; k < 4; k++) exp_tbl[s + k] = 6'(6'h24 + k);
      for (int k = 4; k < 7; k++) exp_tbl[s + k] = 6'h28;
      exp_tbl[s + 7] = 6'h10;
   endtask

   task automatic run(input string name, input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         update_frame = upd_m[c];
         pixel_ready  = ~rdy_lo_m[c];
         reset        = rst_m[c];
         chk($sformatf("%s_c%0d", name, c), {26'd0, w_obs}, {26'd0, exp_tbl[c]});
         step();
      end
      update_frame = 1'b0;
      pixel_ready  = 1'b1;
      reset        = 1'b0;
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      reset        = 1'b1;
      update_frame = 1'b0;
      pixel_ready  = 1'b1;
      step();
      step();
      chk("reset_outputs", {26'd0, w_obs}, 32'd0);
      reset = 1'b0;
      step();

      // Basic frame with ready tied high
      clr();
      upd_m[0] = 1'b1;
      frame_exp(1);
      run("basic", 10);

      // Back-pressure: index 2 held for three cycles
      clr();
      upd_m[0]    = 1'b1;
      rdy_lo_m[3] = 1'b1;
      rdy_lo_m[4] = 1'b1;
      exp_tbl[1]  = 6'h24;
      exp_tbl[2]  = 6'h25;
      exp_tbl[3]  = 6'h26;
      exp_tbl[4]  = 6'h26;
      exp_tbl[5]  = 6'h26;
      exp_tbl[6]  = 6'h27;
      exp_tbl[7]  = 6'h28;
      exp_tbl[8]  = 6'h28;
      exp_tbl[9]  = 6'h28;
      exp_tbl[10] = 6'h10;
      run("stall", 12);

      // Request mid-SEND
      clr();
      upd_m[0] = 1'b1;
      upd_m[3] = 1'b1;
      frame_exp(1);
`ifdef FRAME_SCHEDULER_PENDING_EN
      frame_exp(8);
      exp_tbl[8] = 6'h34;
`endif
      run("midreq", 17);

      // Reset during the second SEND cycle, then a clean frame
      clr();
      upd_m[0]   = 1'b1;
      rst_m[2]   = 1'b1;
      exp_tbl[1] = 6'h24;
      exp_tbl[2] = 6'h25;
      upd_m[5]   = 1'b1;
      frame_exp(6);
      run("midrst", 16);

      // update_frame held high for 20 cycles
      clr();
      for (int i = 0; i < 20; i++) upd_m[i] = 1'b1;
`ifdef FRAME_SCHEDULER_PENDING_EN
      frame_exp(1);
      frame_exp(8);
      frame_exp(15);
      frame_exp(22);
      exp_tbl[8]  = 6'h34;
      exp_tbl[15] = 6'h34;
      exp_tbl[22] = 6'h34;
`else
      frame_exp(1);
      frame_exp(9);
      frame_exp(17);
`endif
      run("hold", 31);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
